// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with separate control/data fields, flush and occupancy.
// Define PIPE_SKID_EN to add a 1-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
  parameter int unsigned             CTRL_W         = 16,
  parameter int unsigned             DATA_W         = 128,
  parameter bit                      CLR_DATA       = 1'b0,
  parameter logic [CTRL_W-1:0]       FLUSH_CTRL_VAL = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              in_xfer, out_xfer;

  assign out_xfer = out_valid_q & out_ready;
  assign in_xfer  = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  // in_ready comes straight from a flop, cutting the out_ready->in_ready path
  assign in_ready  = ~skid_valid_q;
  assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctrl_d   = out_ctrl_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_ctrl_d   = FLUSH_CTRL_VAL;
      skid_ctrl_d  = FLUSH_CTRL_VAL;
      if (CLR_DATA) begin
        out_data_d  = '0;
        skid_data_d = '0;
      end
    end else if (skid_valid_q) begin
      if (out_xfer) begin
        out_ctrl_d   = skid_ctrl_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = FLUSH_CTRL_VAL;
      end
    end else if (in_xfer) begin
      if (out_valid_q && !out_ready) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end else begin
        out_valid_d = 1'b1;
        out_ctrl_d  = in_ctrl;
        out_data_d  = in_data;
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = FLUSH_CTRL_VAL;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= FLUSH_CTRL_VAL;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready  = out_ready | ~out_valid_q;
  assign occupancy = {1'b0, out_valid_q};

  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = FLUSH_CTRL_VAL;
      if (CLR_DATA) out_data_d = '0;
    end else if (in_xfer) begin
      out_valid_d = 1'b1;
      out_ctrl_d  = in_ctrl;
      out_data_d  = in_data;
    end else if (out_xfer) begin
      // Keep the NOP invariant: an empty stage always presents FLUSH_CTRL_VAL
      out_valid_d = 1'b0;
      out_ctrl_d  = FLUSH_CTRL_VAL;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= FLUSH_CTRL_VAL;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: two instances differing only in CLR_DATA share stimulus.
module tb_pipe_stage_reg;

  localparam int unsigned CW  = 16;
  localparam int unsigned DW  = 32;
  localparam logic [CW-1:0] NOP = 16'h0013;
`ifdef PIPE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [CW-1:0] out_ctrl_a, out_ctrl_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [1:0]    occ_a, occ_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b0), .FLUSH_CTRL_VAL(NOP)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_ctrl(out_ctrl_a), .out_data(out_data_a), .occupancy(occ_a));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b1), .FLUSH_CTRL_VAL(NOP)) u_clr (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ctrl(out_ctrl_b), .out_data(out_data_b), .occupancy(occ_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] d, input logic [1:0] o);
    chk({tag, "_valid"}, 64'(out_valid_a), 64'(v));
    chk({tag, "_ctrl"},  64'(out_ctrl_a),  64'(c));
    chk({tag, "_data"},  64'(out_data_a),  64'(d));
    chk({tag, "_occ"},   64'(occ_a),       64'(o));
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    repeat (3) step();
    chk_out("reset", 1'b0, NOP, 32'h0, 2'd0);
    chk("reset_in_ready", 64'(in_ready_a), 64'(1'b1));
    rstn = 1'b1;

    // reset mid-stream
    in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = 32'hDEAD_BEEF;
    step();
    chk_out("capture", 1'b1, 16'hFFFF, 32'hDEAD_BEEF, 2'd1);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, NOP, 32'h0, 2'd0);
    rstn = 1'b1;

    // streaming, no bubbles
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_ctrl = 16'h0100 + CW'(i); in_data = DW'(i);
      #1;
      chk($sformatf("stream_in_ready_%0d", i), 64'(in_ready_a), 64'(1'b1));
      step();
      chk_out($sformatf("stream_%0d", i), 1'b1, 16'h0100 + CW'(i), DW'(i), 2'd1);
    end
    in_valid = 1'b0;
    step();
    chk_out("drain", 1'b0, NOP, 32'h4, 2'd0);

    // stall hold
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0ABC; in_data = 32'hA5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall_in_ready_%0d", i), 64'(in_ready_a), 64'(SKID));
      step();
      chk_out($sformatf("stall_%0d", i), 1'b1, 16'h0ABC, 32'hA5, 2'd1);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0777; in_data = 32'h77;
    #1;
    chk("release_in_ready", 64'(in_ready_a), 64'(1'b1));
    step();
    chk_out("release_replace", 1'b1, 16'h0777, 32'h77, 2'd1);
    in_valid = 1'b0;
    step();
    chk_out("release_empty", 1'b0, NOP, 32'h77, 2'd0);

    // flush with simultaneous input transfer, CLR_DATA 0 vs 1
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0555; in_data = 32'h3C;
    step();
    chk_out("flush_pre", 1'b1, 16'h0555, 32'h3C, 2'd1);
    in_ctrl = 16'h0666; in_data = 32'h99; out_ready = 1'b1; flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready_a), 64'(1'b1));
    step();
    chk_out("flush_keep", 1'b0, NOP, 32'h3C, 2'd0);
    chk("flush_clr_valid", 64'(out_valid_b), 64'(1'b0));
    chk("flush_clr_ctrl",  64'(out_ctrl_b),  64'(NOP));
    chk("flush_clr_data",  64'(out_data_b),  64'(32'h0));
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk_out("flush_post", 1'b0, NOP, 32'h3C, 2'd0);
    chk("flush_post_clr_data", 64'(out_data_b), 64'(32'h0));

`ifdef PIPE_SKID_EN
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0A0A; in_data = 32'hAA;
    step();
    chk_out("skid_a", 1'b1, 16'h0A0A, 32'hAA, 2'd1);
    chk("skid_a_in_ready", 64'(in_ready_a), 64'(1'b1));
    in_ctrl = 16'h0B0B; in_data = 32'hBB;
    step();
    chk_out("skid_b", 1'b1, 16'h0A0A, 32'hAA, 2'd2);
    chk("skid_b_in_ready", 64'(in_ready_a), 64'(1'b0));
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_out("skid_emit_b", 1'b1, 16'h0B0B, 32'hBB, 2'd1);
    chk("skid_drained_in_ready", 64'(in_ready_a), 64'(1'b1));
    step();
    chk_out("skid_empty", 1'b0, NOP, 32'hBB, 2'd0);

    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0C0C; in_data = 32'hCC;
    step();
    in_ctrl = 16'h0D0D; in_data = 32'hDD;
    step();
    chk("skid_full_occ", 64'(occ_a), 64'(2'd2));
    in_valid = 1'b0; flush = 1'b1;
    step();
    chk_out("skid_flush", 1'b0, NOP, 32'hCC, 2'd0);
    chk("skid_flush_in_ready", 64'(in_ready_a), 64'(1'b1));
    flush = 1'b0; out_ready = 1'b1;
    step();
    chk_out("skid_flush_post", 1'b0, NOP, 32'hCC, 2'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
